// File: rtl/signed_result_bcd_pkg.sv
// signed_result_bcd_pkg: shared widths and FSM states for the signed BCD converter
package signed_result_bcd_pkg;
  localparam int DATA_W = 9;
  localparam int NUM_DIGITS = 3;
  localparam int BCD_W = 4;
  localparam int ITER_W = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
endpackage

// File: rtl/bcd_add3_v.sv
// bcd_add3_v: double-dabble digit corrector (i_d >= 5 -> i_d + 3), ports i_d in, o_d out
module bcd_add3_v (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);
  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;
endmodule

// File: rtl/signed_result_bcd_converter_v.sv
// signed_result_bcd_converter_v: 9-bit signed to sign + 3 BCD digits via shift-add-3 FSM; i_valid/o_ready in, o_valid pulse with o_neg/o_bcd_* out
module signed_result_bcd_converter_v
  import signed_result_bcd_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic signed [DATA_W-1:0] i_fu,
  output logic              o_ready,
  output logic              o_valid,
  output logic              o_neg,
  output logic [BCD_W-1:0]  o_bcd_hundreds,
  output logic [BCD_W-1:0]  o_bcd_tens,
  output logic [BCD_W-1:0]  o_bcd_ones
);
  localparam int SW = NUM_DIGITS * BCD_W;
  state_t r_state, w_next;
  logic [ITER_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mag, w_abs, w_mag_sh;
  logic [SW-1:0] r_bcd, w_fix, w_sh;
  logic r_sign, r_nz, w_last;
  logic r_neg;
  logic [BCD_W-1:0] r_h, r_t, r_o;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_fix
    bcd_add3_v u_add3 (.i_d(r_bcd[g*BCD_W +: BCD_W]), .o_d(w_fix[g*BCD_W +: BCD_W]));
  end
  // -256 negates to 9'h100, which reads correctly as unsigned 256
  assign w_abs = i_fu[DATA_W-1] ? $unsigned(-i_fu) : $unsigned(i_fu);
  assign {w_sh, w_mag_sh} = {w_fix[SW-2:0], r_mag, 1'b0};
  assign w_last = (r_cnt == ITER_W'(DATA_W - 1));
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE) ? (i_valid ? CONV : IDLE) :
             (r_state == CONV) ? (w_last ? DONE : CONV) : IDLE;
  end
  // Output registers load on the final shift so digits are visible during DONE
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_mag <= '0;
      r_bcd <= '0;
      r_sign <= 1'b0;
      r_nz <= 1'b0;
      r_neg <= 1'b0;
      r_h <= '0;
      r_t <= '0;
      r_o <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (i_valid) begin
          r_mag <= w_abs;
          r_sign <= i_fu[DATA_W-1];
          r_nz <= |i_fu;
          r_bcd <= '0;
          r_cnt <= '0;
        end
        CONV: begin
          r_bcd <= w_sh;
          r_mag <= w_mag_sh;
          r_cnt <= r_cnt + ITER_W'(1);
          if (w_last) begin
            r_h <= w_sh[2*BCD_W +: BCD_W];
            r_t <= w_sh[BCD_W +: BCD_W];
            r_o <= w_sh[0 +: BCD_W];
            r_neg <= r_sign & r_nz;
          end
        end
        default: ;
      endcase
    end
  end
  assign o_ready = (r_state == IDLE);
  assign o_valid = (r_state == DONE);
  assign o_neg = r_neg;
  assign o_bcd_hundreds = r_h;
  assign o_bcd_tens = r_t;
  assign o_bcd_ones = r_o;
endmodule

// File: tb/tb_signed_result_bcd_converter_v.sv
// tb_signed_result_bcd_converter_v: random + directed checks against a decimal-arithmetic model
module tb_signed_result_bcd_converter_v;
  logic i_clk = 1'b0, i_rst = 1'b1, i_valid = 1'b0;
  logic signed [8:0] i_fu = '0;
  logic o_ready, o_valid, o_neg;
  logic [3:0] o_bcd_hundreds, o_bcd_tens, o_bcd_ones;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit chk_en = 1'b0;
  int m_cnt = 0, m_val = 0;
  logic [12:0] m_exp = '0;
  int vq[$];
  logic [12:0] dq[$];
  signed_result_bcd_converter_v dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_fu(i_fu),
    .o_ready(o_ready), .o_valid(o_valid), .o_neg(o_neg),
    .o_bcd_hundreds(o_bcd_hundreds), .o_bcd_tens(o_bcd_tens), .o_bcd_ones(o_bcd_ones)
  );
  always #5 i_clk = ~i_clk;
  function automatic logic [12:0] expd(int v);
    int a = v < 0 ? -v : v;
    return {v < 0, 4'(a / 100), 4'((a / 10) % 10), 4'(a % 10)};
  endfunction
  task automatic chk(string n, int a, int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(posedge i_clk) begin
    if (i_rst) begin
      m_cnt <= 0;
      m_exp <= '0;
    end else if (m_cnt == 0) begin
      if (i_valid) begin
        m_cnt <= 10;
        m_val <= int'(i_fu);
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) m_exp <= expd(m_val);
    end
  end
  always @(negedge i_clk) if (chk_en) begin
    chk("ready", int'(o_ready), int'(m_cnt == 0));
    chk("valid", int'(o_valid), int'(m_cnt == 1));
    chk("neg", int'(o_neg), int'(m_exp[12]));
    chk("hundreds", int'(o_bcd_hundreds), int'(m_exp[11:8]));
    chk("tens", int'(o_bcd_tens), int'(m_exp[7:4]));
    chk("ones", int'(o_bcd_ones), int'(m_exp[3:0]));
    if (o_valid === 1'b1) begin
      vq.push_back(cyc);
      dq.push_back({o_neg, o_bcd_hundreds, o_bcd_tens, o_bcd_ones});
    end
  end
  task automatic run(int v, int n, int h, int t, int o);
    int k;
    @(posedge i_clk); #2 i_valid = 1'b1; i_fu = 9'(v);
    @(posedge i_clk); #2 i_valid = 1'b0;
    k = 1;
    while (o_valid !== 1'b1 && k < 15) begin
      @(posedge i_clk); #2 k++;
    end
    chk($sformatf("latency_%0d", v), k, 10);
    chk($sformatf("neg_%0d", v), int'(o_neg), n);
    chk($sformatf("hun_%0d", v), int'(o_bcd_hundreds), h);
    chk($sformatf("ten_%0d", v), int'(o_bcd_tens), t);
    chk($sformatf("one_%0d", v), int'(o_bcd_ones), o);
    @(posedge i_clk); #2 chk($sformatf("ready_after_%0d", v), int'(o_ready), 1);
  endtask
  initial begin
    int bb[3] = '{1, -1, 255};
    logic [12:0] be[3] = '{13'h0001, 13'h1001, 13'h0255};
    int k;
    @(posedge i_clk); #1 chk_en = 1'b1;
    repeat (2) @(posedge i_clk);
    #2;
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_neg", int'(o_neg), 0);
    chk("rst_digits", int'({o_bcd_hundreds, o_bcd_tens, o_bcd_ones}), 0);
    i_rst = 1'b0;
    run(90, 0, 0, 9, 0);
    run(-225, 1, 2, 2, 5);
    run(-165, 1, 1, 6, 5);
    run(-256, 1, 2, 5, 6);
    run(0, 0, 0, 0, 0);
    run(255, 0, 2, 5, 5);
    vq.delete(); dq.delete();
    @(posedge i_clk); #2 i_valid = 1'b1; i_fu = 9'sd90;
    @(posedge i_clk); #2 i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #2 i_valid = 1'b1; i_fu = -9'sd75;
    repeat (6) @(posedge i_clk);
    #2 i_valid = 1'b0;
    repeat (20) @(posedge i_clk);
    chk("busy_count", vq.size(), 1);
    if (dq.size() > 0) chk("busy_digits", int'(dq[0]), int'(13'h0090));
    vq.delete(); dq.delete();
    @(posedge i_clk); #2 i_valid = 1'b1; i_fu = -9'sd225;
    @(posedge i_clk); #2 i_valid = 1'b0;
    repeat (4) @(posedge i_clk);
    #2 i_rst = 1'b1; i_valid = 1'b1; i_fu = 9'sd5;
    @(posedge i_clk); #2 i_rst = 1'b0; i_valid = 1'b0;
    chk("abort_ready", int'(o_ready), 1);
    chk("abort_out", int'({o_neg, o_bcd_hundreds, o_bcd_tens, o_bcd_ones}), 0);
    repeat (15) @(posedge i_clk);
    chk("abort_no_valid", vq.size(), 0);
    vq.delete(); dq.delete();
    @(posedge i_clk); #2 i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_fu = 9'(bb[i]);
      k = 0;
      while (o_ready !== 1'b1 && k < 20) begin
        @(posedge i_clk); #2 k++;
      end
      if (k >= 20) chk("b2b_ready_timeout", k, 0);
      @(posedge i_clk); #2;
    end
    i_valid = 1'b0;
    repeat (15) @(posedge i_clk);
    chk("b2b_count", vq.size(), 3);
    for (int i = 0; i < 3 && i < dq.size(); i++) chk($sformatf("b2b_digits_%0d", i), int'(dq[i]), int'(be[i]));
    for (int i = 1; i < 3 && i < vq.size(); i++) chk($sformatf("b2b_gap_%0d", i), vq[i] - vq[i-1], 11);
    repeat (400) begin
      @(posedge i_clk); #2;
      i_rst = ($urandom_range(0, 59) == 0);
      i_valid = 1'($urandom_range(0, 1));
      i_fu = 9'($urandom);
    end
    #0 i_rst = 1'b0; i_valid = 1'b0;
    repeat (15) @(posedge i_clk);
    #2 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/signed_result_bcd_converter_v.md
# signed_result_bcd_converter_v

Sequential converter downstream of the signed arithmetic stage. It accepts one 9-bit two's-complement result per handshake and produces a sign flag plus three BCD digits of the magnitude. The conversion uses an iterative shift-add-3 (double-dabble) FSM. The outputs feed the seven-segment display stage; the full calculator output range (-225..+90) and the full 9-bit range (-256..+255) are both covered.

## Interface
- DATA_W, 9: width of the signed input. Only 9 is supported.
- NUM_DIGITS, 3: number of BCD output digits. Requires 10^NUM_DIGITS > 2^(DATA_W-1).
- i_clk  input  1  single clock. All state updates on the rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_valid  input  1  upstream result valid.
- i_fu  input  DATA_W (signed)  result from the arithmetic stage.
- o_ready  output  1  block can accept a value this cycle.
- o_valid  output  1  one-cycle pulse: digits and sign are updated.
- o_neg  output  1  result is negative.
- o_bcd_hundreds  output  4  magnitude hundreds digit, 0..2.
- o_bcd_tens  output  4  magnitude tens digit, 0..9.
- o_bcd_ones  output  4  magnitude ones digit, 0..9.

## Operation
- **States:** IDLE, CONV, DONE.
- **Reset:** state=IDLE, iteration counter=0, scratch registers=0. Outputs: o_ready=1, o_valid=0, o_neg=0, all digits=0.
- **IDLE:**
  - o_ready=1.
  - On i_valid=1, capture i_fu. Compute the magnitude as a DATA_W-bit unsigned value: -256 gives 256, which fits in 9 unsigned bits. Latch the sign and clear the BCD scratch. Counter=0. Go to CONV.
  - i_valid=0 leaves the block in IDLE.
- **CONV:**
  - o_ready=0.
  - Each cycle, every BCD scratch digit ≥5 gets +3. Then {bcd, mag} is shifted left by 1. Counter increments.
  - After DATA_W (9) iterations, go to DONE.
- **DONE:**
  - Copy the scratch digits to o_bcd_*. Set o_neg to the latched sign ANDed with (magnitude≠0), so there is no negative zero.
  - o_valid=1 for this cycle only. o_ready=0. Next state is IDLE.
- **Output holding:** o_bcd_* and o_neg hold their last values until the next DONE or a reset.
- **Inputs while busy:** i_valid during CONV or DONE is ignored and the value is dropped. Upstream must hold i_valid until o_ready=1.
- **Digit correction:** add-3 is applied before each shift, including the first. A corrected digit never exceeds 4 bits because its value is ≤ 12 before the shift.

## Timing
- The accept edge is cycle 0, with IDLE, i_valid=1 and o_ready=1.
- CONV occupies cycles 1..9.
- DONE is cycle 10: o_valid is high and new digits are visible.
- IDLE again at cycle 11, with o_ready=1.
- Latency from accept to o_valid is 10 cycles. Throughput is one result per 11 cycles.
- **Reset mid-conversion:** i_rst=1 in any state returns the block to its reset values on the next edge. No o_valid is issued for the aborted value.
- **Reset and i_valid together:** if i_rst and i_valid are both 1, reset wins and nothing is captured.
- **Boundary values:**
  - i_fu = -256 gives o_neg=1 and 2/5/6.
  - +255 gives 2/5/5.
  - 0 gives o_neg=0 and 0/0/0.

## Structure
- Package signed_result_bcd_pkg holds:
  - the state enum {IDLE, CONV, DONE};
  - DATA_W=9, NUM_DIGITS=3, BCD_W=4;
  - ITER_W = $clog2(DATA_W+1), the counter width.
- Sub-module bcd_add3_v is a combinational 4-bit digit corrector: out = (in ≥ 5) ? in+3 : in. It is instantiated once per digit.
- The top level holds the FSM, counter, magnitude/scratch shift register and output registers.

## Test plan
- **Reset:** hold i_rst for 3 cycles. Required: o_ready=1, o_valid=0, o_neg=0, digits 0/0/0.
- **Positive value:** i_fu=+90 (a=15, b=0), with i_valid pulsed for 1 cycle. Required: o_valid exactly 10 cycles later, o_neg=0, digits 0/9/0, o_ready=1 the next cycle.
- **Negative extremes:**
  - i_fu=-225 (a=0, b=15 → -165; also check -225): o_neg=1, 2/2/5.
  - i_fu=-256: o_neg=1, 2/5/6.
  - i_fu=0: o_neg=0, 0/0/0.
- **Busy input dropped:** accept +90, then present i_fu=-75 with i_valid during cycles 3..8. Required: a single o_valid with 0/9/0, and the -75 value is dropped.
- **Reset mid-conversion:** accept -225, then assert i_rst at cycle 5. Required: no o_valid, all outputs 0, o_ready=1 one cycle after reset deasserts.
- **Back-to-back:** hold i_valid high continuously with values +1, -1, +255. Required: an o_valid every 11 cycles, giving 0/0/1, neg 0/0/1, then 2/5/5.
